// File: rtl/state_data_pkg.sv
// Shared types and defaults for the state/data sequencer and its decoder.
package state_data_pkg;

    typedef enum logic {
        WRAP     = 1'b0,
        SATURATE = 1'b1
    } mode_e;

    localparam int DEF_STATE_W    = 4;
    localparam int DEF_DATA_W     = 3;
    localparam int DEF_LAST_STATE = 11;

    function automatic int min_w(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/state_data_decode.sv
// Combinational decode of the sequencer state into the data word.
module state_data_decode
    import state_data_pkg::*;
#(
    parameter int STATE_W    = DEF_STATE_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int LAST_STATE = DEF_LAST_STATE
) (
    input  logic [STATE_W-1:0] state,
    output logic [DATA_W-1:0]  data
);

    localparam int                 EXT_W  = min_w(STATE_W, DATA_W);
    localparam logic [STATE_W-1:0] LAST_S = STATE_W'(LAST_STATE);
    localparam logic [STATE_W-1:0] PEN_S  = STATE_W'(LAST_STATE - 1);

    logic [DATA_W-1:0] ext;
    logic [DATA_W-1:0] ones;
    logic [DATA_W-1:0] ones_lsb0;

    always_comb begin
        ext              = '0;
        ext[EXT_W-1:0]   = state[EXT_W-1:0];
        ones             = '1;
        ones_lsb0        = '1;
        ones_lsb0[0]     = 1'b0;
        // State 0 falls into the default and decodes to 0 via the zero slice.
        case (state)
            LAST_S:  data = ones;
            PEN_S:   data = ones_lsb0;
            default: data = (state > LAST_S) ? '0 : ext;
        endcase
    end

endmodule

// File: rtl/state_data_seq.sv
// Bounded up/down state sequencer with load, wrap/saturate end behaviour and registered decode.
module state_data_seq
    import state_data_pkg::*;
#(
    parameter int    STATE_W    = DEF_STATE_W,
    parameter int    DATA_W     = DEF_DATA_W,
    parameter int    LAST_STATE = DEF_LAST_STATE,
    parameter mode_e MODE       = WRAP
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               En,
    input  logic               Dir,
    input  logic               Load,
    input  logic [STATE_W-1:0] LoadState,
    output logic [STATE_W-1:0] state,
    output logic [DATA_W-1:0]  data,
    output logic               wrap,
    output logic               range_err
);

    generate
        if (LAST_STATE > 2**STATE_W - 1 || LAST_STATE < 1) begin : g_bad_last
            $error("state_data_seq: LAST_STATE out of range for STATE_W");
        end
    endgenerate

    localparam logic [STATE_W-1:0] LAST_S = STATE_W'(LAST_STATE);
    localparam logic [STATE_W-1:0] ONE    = STATE_W'(1);

    logic [STATE_W-1:0] state_nxt;
    logic [DATA_W-1:0]  dec_data;
    logic               wrap_nxt;
    logic               err_nxt;

    state_data_decode #(
        .STATE_W    (STATE_W),
        .DATA_W     (DATA_W),
        .LAST_STATE (LAST_STATE)
    ) u_decode (
        .state (state),
        .data  (dec_data)
    );

    // Load beats En; an out-of-range load never produces a wrap pulse.
    always_comb begin
        state_nxt = state;
        wrap_nxt  = 1'b0;
        err_nxt   = 1'b0;
        if (Load) begin
            if (LoadState > LAST_S) begin
                err_nxt   = 1'b1;
                state_nxt = (MODE == SATURATE) ? LAST_S : '0;
            end else begin
                state_nxt = LoadState;
            end
        end else if (En) begin
            if (Dir) begin
                if (state == LAST_S) begin
                    wrap_nxt = 1'b1;
                    if (MODE == WRAP) state_nxt = '0;
                end else begin
                    state_nxt = state + ONE;
                end
            end else begin
                if (state == '0) begin
                    wrap_nxt = 1'b1;
                    if (MODE == WRAP) state_nxt = LAST_S;
                end else begin
                    state_nxt = state - ONE;
                end
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state     <= '0;
            data      <= '0;
            wrap      <= 1'b0;
            range_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            data      <= dec_data;
            wrap      <= wrap_nxt;
            range_err <= err_nxt;
        end
    end

endmodule

// File: tb/tb_state_data_seq.sv
// Scoreboard bench: three sequencer configurations driven in lockstep against a reference model.
module tb_state_data_seq;
    import state_data_pkg::*;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic       En = 1'b0, Dir = 1'b0, Load = 1'b0;
    logic [3:0] LoadState = 4'd0;
    logic [2:0] load3;

    logic [3:0] st0, st1;
    logic [2:0] dt0, dt1;
    logic [2:0] st2;
    logic [3:0] dt2;
    logic       wr0, wr1, wr2, er0, er1, er2;

    assign load3 = LoadState[2:0];

    always #5 Clock = ~Clock;

    state_data_seq #(.STATE_W(4), .DATA_W(3), .LAST_STATE(11), .MODE(WRAP)) u_wrap (
        .Clock(Clock), .Reset(Reset), .En(En), .Dir(Dir), .Load(Load), .LoadState(LoadState),
        .state(st0), .data(dt0), .wrap(wr0), .range_err(er0));

    state_data_seq #(.STATE_W(4), .DATA_W(3), .LAST_STATE(11), .MODE(SATURATE)) u_sat (
        .Clock(Clock), .Reset(Reset), .En(En), .Dir(Dir), .Load(Load), .LoadState(LoadState),
        .state(st1), .data(dt1), .wrap(wr1), .range_err(er1));

    state_data_seq #(.STATE_W(3), .DATA_W(4), .LAST_STATE(7), .MODE(WRAP)) u_w3 (
        .Clock(Clock), .Reset(Reset), .En(En), .Dir(Dir), .Load(Load), .LoadState(load3),
        .state(st2), .data(dt2), .wrap(wr2), .range_err(er2));

    typedef struct {
        int st;
        int dt;
        bit wr;
        bit er;
    } exp_t;

    exp_t q0[$], q1[$], q2[$];
    int   total = 0;
    int   bad   = 0;

    int   mst[3]   = '{0, 0, 0};
    int   lastv[3] = '{11, 11, 7};
    int   dwv[3]   = '{3, 3, 4};
    int   spanv[3] = '{16, 16, 8};
    bit   satv[3]  = '{1'b0, 1'b1, 1'b0};

    // Spec decode table written with plain integer arithmetic.
    function automatic int ref_decode(input int i, input int s);
        int top;
        top = (1 << dwv[i]) - 1;
        if (s == lastv[i])     return top;
        if (s == lastv[i] - 1) return top - 1;
        if (s == 0)            return 0;
        return s % (1 << dwv[i]);
    endfunction

    function automatic exp_t ref_step(input int i, input bit en, input bit dir, input bit ld, input int lds);
        exp_t e;
        int   v;
        int   nxt;
        e.dt = ref_decode(i, mst[i]);
        e.wr = 1'b0;
        e.er = 1'b0;
        v    = lds % spanv[i];
        if (ld) begin
            if (v > lastv[i]) begin
                e.er   = 1'b1;
                mst[i] = satv[i] ? lastv[i] : 0;
            end else begin
                mst[i] = v;
            end
        end else if (en) begin
            nxt = dir ? mst[i] + 1 : mst[i] - 1;
            if (nxt > lastv[i] || nxt < 0) begin
                e.wr = 1'b1;
                if (!satv[i]) mst[i] = dir ? 0 : lastv[i];
            end else begin
                mst[i] = nxt;
            end
        end
        e.st = mst[i];
        return e;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_zero_all(input string tag);
        check({tag, " w.state"}, int'(st0), 0);
        check({tag, " w.data"},  int'(dt0), 0);
        check({tag, " w.wrap"},  int'(wr0), 0);
        check({tag, " w.err"},   int'(er0), 0);
        check({tag, " s.state"}, int'(st1), 0);
        check({tag, " s.data"},  int'(dt1), 0);
        check({tag, " s.wrap"},  int'(wr1), 0);
        check({tag, " s.err"},   int'(er1), 0);
        check({tag, " n.state"}, int'(st2), 0);
        check({tag, " n.data"},  int'(dt2), 0);
        check({tag, " n.wrap"},  int'(wr2), 0);
        check({tag, " n.err"},   int'(er2), 0);
    endtask

    // Monitor: one expected entry per instance per clock edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge Clock);
            #2;
            if (q0.size() > 0) begin
                e = q0.pop_front();
                check("w.state", int'(st0), e.st);
                check("w.data",  int'(dt0), e.dt);
                check("w.wrap",  int'(wr0), int'(e.wr));
                check("w.err",   int'(er0), int'(e.er));
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                check("s.state", int'(st1), e.st);
                check("s.data",  int'(dt1), e.dt);
                check("s.wrap",  int'(wr1), int'(e.wr));
                check("s.err",   int'(er1), int'(e.er));
            end
            if (q2.size() > 0) begin
                e = q2.pop_front();
                check("n.state", int'(st2), e.st);
                check("n.data",  int'(dt2), e.dt);
                check("n.wrap",  int'(wr2), int'(e.wr));
                check("n.err",   int'(er2), int'(e.er));
            end
        end
    end

    // Drive one cycle of inputs; optionally pulse reset mid-cycle before the edge.
    task automatic step(input bit en, input bit dir, input bit ld, input int lds, input bit rst_pulse);
        @(negedge Clock);
        En        = en;
        Dir       = dir;
        Load      = ld;
        LoadState = 4'(lds);
        if (rst_pulse) begin
            #1 Reset = 1'b1;
            #1 check_zero_all("async_rst");
            Reset = 1'b0;
            for (int i = 0; i < 3; i++) mst[i] = 0;
        end
        q0.push_back(ref_step(0, en, dir, ld, lds));
        q1.push_back(ref_step(1, en, dir, ld, lds));
        q2.push_back(ref_step(2, en, dir, ld, lds));
    endtask

    initial begin
        #1 Reset = 1'b1;
        #1 check_zero_all("reset");
        Reset = 1'b0;

        // Count up through and past the end of range.
        repeat (13) step(1'b1, 1'b1, 1'b0, 0, 1'b0);

        // Park at the last state and keep pushing up.
        step(1'b0, 1'b0, 1'b1, 11, 1'b0);
        repeat (3) step(1'b1, 1'b1, 1'b0, 0, 1'b0);

        // Out-of-range load, down-wrap from zero, load beating En.
        step(1'b0, 1'b0, 1'b1, 15, 1'b0);
        step(1'b0, 1'b0, 1'b1, 0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 5, 1'b0);

        // Reset pulse between edges with state 7 and En pending.
        step(1'b0, 1'b0, 1'b1, 7, 1'b0);
        step(1'b0, 1'b0, 1'b0, 0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 0, 1'b1);

        // Full sweep of the narrow configuration.
        step(1'b0, 1'b0, 1'b1, 0, 1'b0);
        repeat (9) step(1'b1, 1'b1, 1'b0, 0, 1'b0);
        repeat (9) step(1'b1, 1'b0, 1'b0, 0, 1'b0);

        repeat (400) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0), int'($urandom_range(0, 15)),
                 ($urandom_range(0, 49) == 0));
        end

        @(negedge Clock);
        @(negedge Clock);
        check("drain", q0.size() + q1.size() + q2.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
